// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the RGB LCD panel path.
// Holds the panel ID constants, the strap-code-to-ID map and the sequencer
// state encoding. The timing driver imports the same ID constants.
package lcd_pkg;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_1018 = 16'h1018;

  typedef enum logic [2:0] {
    SAMPLE,
    PRST,
    WRDY,
    DRVON,
    ON,
    BLOFF,
    OFF
  } state_t;

  typedef struct packed {
    logic [15:0] id;
    logic        err;
  } id_map_t;

  // Strap code is {B7,G7,R7}. Unknown codes fall back to the 4342 panel
  // and raise the error flag so software can tell a real 4342 apart.
  function automatic id_map_t strap_to_id(input logic [2:0] code);
    id_map_t m;
    m.id  = ID_4342;
    m.err = 1'b0;
    case (code)
      3'b000:  m.id = ID_4342;
      3'b001:  m.id = ID_7084;
      3'b010:  m.id = ID_7016;
      3'b100:  m.id = ID_1018;
      default: begin
        m.id  = ID_4342;
        m.err = 1'b1;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lcd_init_seq_if.sv
// lcd_init_seq_if: board-side and driver-side signals of the LCD sequencer.
//   strap_in  : {B7,G7,R7} read from the RGB bus while it is tri-stated
//   pd_req    : single-cycle power-down request
//   pu_req    : single-cycle power-up request
//   rgb_oe    : 1 = FPGA drives the RGB bus, 0 = tri-stated for strap read
//   lcd_id    : panel ID for the timing driver
//   id_valid  : lcd_id latched
//   id_err    : strap code unrecognised, fallback ID in use
//   lcd_rst_n : panel reset, active-low
//   drv_rst   : holds the timing driver in reset
//   lcd_bl    : backlight enable
//   ready     : sequence complete, panel displaying
// slave is the sequencer side, master is the side that drives the requests.
interface lcd_init_seq_if;
  import lcd_pkg::*;

  logic [2:0]  strap_in;
  logic        pd_req;
  logic        pu_req;
  logic        rgb_oe;
  logic [15:0] lcd_id;
  logic        id_valid;
  logic        id_err;
  logic        lcd_rst_n;
  logic        drv_rst;
  logic        lcd_bl;
  logic        ready;

  modport slave (
    input  strap_in, pd_req, pu_req,
    output rgb_oe, lcd_id, id_valid, id_err, lcd_rst_n, drv_rst, lcd_bl, ready
  );

  modport master (
    output strap_in, pd_req, pu_req,
    input  rgb_oe, lcd_id, id_valid, id_err, lcd_rst_n, drv_rst, lcd_bl, ready
  );

endinterface

// File: rtl/lcd_strap_filter.sv
// lcd_strap_filter: synchronises the panel ID straps and debounces them.
//   clk_i    : sequencer clock
//   rst_i    : synchronous active-high reset
//   strap_i  : raw {B7,G7,R7} from the pins
//   en_i     : sampling window open; while low the run length is cleared
//   code_o   : synchronised strap code
//   stable_o : strobe, this cycle's sample completes N_STABLE identical ones
module lcd_strap_filter #(
  parameter int N_STABLE = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] strap_i,
  input  logic       en_i,
  output logic [2:0] code_o,
  output logic       stable_o
);

  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] prev_q;
  logic [3:0] run_q;
  logic [3:0] run_d;

  // A fresh window or a changed code starts a new run of one sample.
  // Saturating at 15 keeps the counter from wrapping if the window stays open.
  always_comb begin
    run_d = 4'd1;
    if (run_q != 4'd0 && sync2_q == prev_q) begin
      run_d = (run_q == 4'd15) ? run_q : run_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      run_q   <= '0;
    end else begin
      sync1_q <= strap_i;
      sync2_q <= sync1_q;
      if (en_i) begin
        prev_q <= sync2_q;
        run_q  <= run_d;
      end else begin
        run_q  <= '0;
      end
    end
  end

  assign code_o   = sync2_q;
  assign stable_o = en_i && (run_d == 4'(N_STABLE));

endmodule

// File: rtl/lcd_init_seq.sv
// lcd_init_seq: power-up and configuration sequencer for the RGB LCD panel.
// Reads the ID straps with the RGB bus tri-stated, latches lcd_id, pulses the
// panel reset, releases the timing driver and then enables the backlight.
// Handles runtime power-down (pd_req) and power-up (pu_req).
//   lcd_clk : sequencer and pixel clock
//   sys_rst : synchronous active-high reset
//   bus     : strap/request inputs and all sequencer outputs (slave modport)
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int T_SETTLE = 1000,
  parameter int N_STABLE = 4,
  parameter int T_RST    = 50000,
  parameter int T_RDY    = 100000,
  parameter int T_BL     = 200000,
  parameter int CW       = 24
) (
  input  logic          lcd_clk,
  input  logic          sys_rst,
  lcd_init_seq_if.slave bus
);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(T_SETTLE - 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(T_RST - 1);
  localparam logic [CW-1:0] RDY_LAST    = CW'(T_RDY - 1);
  localparam logic [CW-1:0] BL_LAST     = CW'(T_BL - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          rgb_oe_q;
  logic [15:0]   lcd_id_q;
  logic          id_valid_q;
  logic          id_err_q;
  logic          lcd_rst_n_q;
  logic          drv_rst_q;
  logic          lcd_bl_q;
  logic          ready_q;

  logic          sample_en;
  logic [2:0]    strap_code;
  logic          strap_stable;
  id_map_t       strap_id;

  // Sampling starts once the settle counter has parked at its last value.
  assign sample_en = (state_q == SAMPLE) && (cnt_q == SETTLE_LAST);
  assign strap_id  = strap_to_id(strap_code);

  lcd_strap_filter #(
    .N_STABLE (N_STABLE)
  ) u_strap_filter (
    .clk_i    (lcd_clk),
    .rst_i    (sys_rst),
    .strap_i  (bus.strap_in),
    .en_i     (sample_en),
    .code_o   (strap_code),
    .stable_o (strap_stable)
  );

  // Outputs are set on the same edge that moves the state, so each output
  // flop already holds the value belonging to the state being entered.
  // rgb_oe and drv_rst always change together, which keeps the driver in
  // reset whenever the RGB bus is tri-stated.
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      state_q     <= SAMPLE;
      cnt_q       <= '0;
      rgb_oe_q    <= 1'b0;
      lcd_id_q    <= ID_4342;
      id_valid_q  <= 1'b0;
      id_err_q    <= 1'b0;
      lcd_rst_n_q <= 1'b1;
      drv_rst_q   <= 1'b1;
      lcd_bl_q    <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        SAMPLE: begin
          if (cnt_q != SETTLE_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (strap_stable) begin
            lcd_id_q    <= strap_id.id;
            id_err_q    <= strap_id.err;
            id_valid_q  <= 1'b1;
            lcd_rst_n_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= PRST;
          end
        end
        PRST: begin
          if (cnt_q == RST_LAST) begin
            lcd_rst_n_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= WRDY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WRDY: begin
          if (cnt_q == RDY_LAST) begin
            rgb_oe_q  <= 1'b1;
            drv_rst_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= DRVON;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRVON: begin
          // A power-down here skips ON, so the backlight never comes on.
          if (bus.pd_req) begin
            lcd_bl_q <= 1'b0;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            state_q  <= BLOFF;
          end else if (cnt_q == BL_LAST) begin
            lcd_bl_q <= 1'b1;
            ready_q  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ON;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ON: begin
          if (bus.pd_req) begin
            lcd_bl_q <= 1'b0;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            state_q  <= BLOFF;
          end
        end
        BLOFF: begin
          if (cnt_q == BL_LAST) begin
            drv_rst_q <= 1'b1;
            rgb_oe_q  <= 1'b0;
            cnt_q     <= '0;
            state_q   <= OFF;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        OFF: begin
          // lcd_id stays as the last value until the re-read latches a new one.
          if (bus.pu_req) begin
            id_valid_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= SAMPLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= SAMPLE;
        end
      endcase
    end
  end

  assign bus.rgb_oe    = rgb_oe_q;
  assign bus.lcd_id    = lcd_id_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_err    = id_err_q;
  assign bus.lcd_rst_n = lcd_rst_n_q;
  assign bus.drv_rst   = drv_rst_q;
  assign bus.lcd_bl    = lcd_bl_q;
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// tb_lcd_init_seq: self-checking bench for lcd_init_seq with short timings
// (T_SETTLE=8, N_STABLE=4, T_RST=10, T_RDY=6, T_BL=5).
// Expected IDs are queued when straps are applied; a monitor compares them
// whenever id_valid rises. Sequence timing is checked by cycle counting.
module tb_lcd_init_seq;
  import lcd_pkg::*;

  logic lcd_clk;
  logic sys_rst;

  int assertCount = 0;
  int failCount   = 0;
  logic blSeen    = 1'b0;
  logic prevValid = 1'b0;

  typedef struct {
    logic [15:0] id;
    logic        err;
    string       tag;
  } exp_t;

  exp_t expQ[$];

  lcd_init_seq_if bus_if();

  lcd_init_seq #(
    .T_SETTLE (8),
    .N_STABLE (4),
    .T_RST    (10),
    .T_RDY    (6),
    .T_BL     (5),
    .CW       (24)
  ) dut (
    .lcd_clk (lcd_clk),
    .sys_rst (sys_rst),
    .bus     (bus_if)
  );

  // Free-running 100 MHz clock.
  initial begin
    lcd_clk = 1'b0;
    forever #5 lcd_clk = ~lcd_clk;
  end

  // Hard stop in case a wait is never satisfied despite the bounds.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] strap, input logic rst);
    bus_if.strap_in = strap;
    sys_rst         = rst;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge lcd_clk);
    #1;
  endtask

  function automatic logic sigVal(input int which);
    case (which)
      0:       return bus_if.id_valid;
      1:       return bus_if.lcd_rst_n;
      2:       return bus_if.rgb_oe;
      3:       return bus_if.drv_rst;
      4:       return bus_if.lcd_bl;
      default: return bus_if.ready;
    endcase
  endfunction

  // Counts cycles until the selected output reaches val. When pulseAt >= 0,
  // pd_req and pu_req are pulsed together on that cycle to prove they are
  // ignored by the state being measured.
  task automatic waitSig(input string name, input int which, input logic val,
                         input int maxCyc, input int pulseAt, output int cyc);
    cyc = 0;
    while (sigVal(which) !== val && cyc < maxCyc) begin
      if (cyc == pulseAt) begin
        bus_if.pd_req = 1'b1;
        bus_if.pu_req = 1'b1;
      end
      tick(1);
      bus_if.pd_req = 1'b0;
      bus_if.pu_req = 1'b0;
      cyc++;
    end
    if (sigVal(which) !== val) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s timeout: got %0b after %0d cycles, expected %0b",
               name, sigVal(which), cyc, val);
    end
  endtask

  task automatic pulseReq(input logic pd, input logic pu);
    bus_if.pd_req = pd;
    bus_if.pu_req = pu;
    tick(1);
    bus_if.pd_req = 1'b0;
    bus_if.pu_req = 1'b0;
  endtask

  task automatic pushExp(input logic [15:0] id, input logic err, input string tag);
    exp_t e;
    e.id  = id;
    e.err = err;
    e.tag = tag;
    expQ.push_back(e);
  endtask

  // Scoreboard monitor plus the drv_rst/rgb_oe invariant and backlight watch.
  always @(negedge lcd_clk) begin
    if (bus_if.id_valid === 1'b1 && prevValid === 1'b0) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected id latch: got %0h, expected none", bus_if.lcd_id);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput({e.tag, " lcd_id"}, 32'(bus_if.lcd_id), 32'(e.id));
        checkOutput({e.tag, " id_err"}, 32'(bus_if.id_err), 32'(e.err));
      end
    end
    prevValid <= bus_if.id_valid;
    if (bus_if.lcd_bl === 1'b1) blSeen <= 1'b1;
    if (bus_if.drv_rst === 1'b0) begin
      checkOutput("invariant rgb_oe while drv_rst=0", 32'(bus_if.rgb_oe), 32'd1);
    end
  end

  // Runs the post-latch part of the sequence and checks its timing.
  task automatic checkPowerUp(input string tag, input int pulseRst, input int pulseRdy);
    int cyc;
    waitSig({tag, " lcd_rst_n fall"}, 1, 1'b0, 40, -1, cyc);
    waitSig({tag, " lcd_rst_n rise"}, 1, 1'b1, 40, pulseRst, cyc);
    checkOutput({tag, " lcd_rst_n low cycles"}, 32'(cyc), 32'd10);
    waitSig({tag, " rgb_oe rise"}, 2, 1'b1, 40, pulseRdy, cyc);
    checkOutput({tag, " rgb_oe delay"}, 32'(cyc), 32'd6);
    checkOutput({tag, " drv_rst with rgb_oe"}, 32'(bus_if.drv_rst), 32'd0);
    waitSig({tag, " lcd_bl rise"}, 4, 1'b1, 40, -1, cyc);
    checkOutput({tag, " lcd_bl delay"}, 32'(cyc), 32'd5);
    checkOutput({tag, " ready"}, 32'(bus_if.ready), 32'd1);
  endtask

  initial begin
    int cyc;
    bus_if.pd_req = 1'b0;
    bus_if.pu_req = 1'b0;

    // Reset values, straps 001 already present.
    applyStimulus(3'b001, 1'b1);
    tick(2);
    checkOutput("reset rgb_oe", 32'(bus_if.rgb_oe), 32'd0);
    checkOutput("reset lcd_id", 32'(bus_if.lcd_id), 32'h4342);
    checkOutput("reset id_valid", 32'(bus_if.id_valid), 32'd0);
    checkOutput("reset id_err", 32'(bus_if.id_err), 32'd0);
    checkOutput("reset lcd_rst_n", 32'(bus_if.lcd_rst_n), 32'd1);
    checkOutput("reset drv_rst", 32'(bus_if.drv_rst), 32'd1);
    checkOutput("reset lcd_bl", 32'(bus_if.lcd_bl), 32'd0);
    checkOutput("reset ready", 32'(bus_if.ready), 32'd0);

    // Scenario 1: straps 001 -> 7084. Latch after 8 settle + 4 samples.
    $display("[TB] scenario 1: straps 001");
    pushExp(16'h7084, 1'b0, "s1");
    applyStimulus(3'b001, 1'b0);
    waitSig("s1 id_valid", 0, 1'b1, 100, -1, cyc);
    checkOutput("s1 id_valid latency", 32'(cyc), 32'd11);
    checkPowerUp("s1", -1, -1);

    // Scenario 3: unknown code 111 falls back to 4342 with id_err.
    $display("[TB] scenario 3: straps 111");
    applyStimulus(3'b111, 1'b1);
    tick(2);
    pushExp(16'h4342, 1'b1, "s3");
    applyStimulus(3'b111, 1'b0);
    waitSig("s3 id_valid", 0, 1'b1, 100, -1, cyc);
    checkPowerUp("s3", -1, -1);

    // Scenario 4: power-down from ON, then power-up with straps 100.
    $display("[TB] scenario 4: power-down / power-up");
    applyStimulus(3'b100, 1'b0);
    tick(3);
    pulseReq(1'b1, 1'b0);
    checkOutput("s4 lcd_bl after pd", 32'(bus_if.lcd_bl), 32'd0);
    checkOutput("s4 ready after pd", 32'(bus_if.ready), 32'd0);
    checkOutput("s4 drv_rst still low", 32'(bus_if.drv_rst), 32'd0);
    waitSig("s4 drv_rst rise", 3, 1'b1, 40, -1, cyc);
    checkOutput("s4 drv_rst delay", 32'(cyc), 32'd5);
    checkOutput("s4 rgb_oe off", 32'(bus_if.rgb_oe), 32'd0);
    checkOutput("s4 id_valid held", 32'(bus_if.id_valid), 32'd1);
    checkOutput("s4 lcd_id held", 32'(bus_if.lcd_id), 32'h4342);
    pushExp(16'h1018, 1'b0, "s4");
    pulseReq(1'b0, 1'b1);
    checkOutput("s4 id_valid cleared", 32'(bus_if.id_valid), 32'd0);
    waitSig("s4 id_valid", 0, 1'b1, 100, -1, cyc);
    checkOutput("s4 id_valid latency", 32'(cyc), 32'd11);
    checkPowerUp("s4", -1, -1);

    // Scenario 5: reset in the middle of PRST, then stray requests ignored.
    $display("[TB] scenario 5: reset mid-PRST");
    applyStimulus(3'b001, 1'b1);
    tick(2);
    pushExp(16'h7084, 1'b0, "s5a");
    applyStimulus(3'b001, 1'b0);
    waitSig("s5 id_valid", 0, 1'b1, 100, -1, cyc);
    tick(4);
    checkOutput("s5 in PRST", 32'(bus_if.lcd_rst_n), 32'd0);
    applyStimulus(3'b010, 1'b1);
    tick(1);
    checkOutput("s5 rst lcd_rst_n", 32'(bus_if.lcd_rst_n), 32'd1);
    checkOutput("s5 rst drv_rst", 32'(bus_if.drv_rst), 32'd1);
    checkOutput("s5 rst id_valid", 32'(bus_if.id_valid), 32'd0);
    checkOutput("s5 rst lcd_id", 32'(bus_if.lcd_id), 32'h4342);
    checkOutput("s5 rst rgb_oe", 32'(bus_if.rgb_oe), 32'd0);
    pushExp(16'h7016, 1'b0, "s5b");
    applyStimulus(3'b010, 1'b0);
    waitSig("s5 id_valid after rst", 0, 1'b1, 100, 3, cyc);
    checkOutput("s5 SAMPLE restart latency", 32'(cyc), 32'd11);
    checkPowerUp("s5", 3, 2);

    // Scenario 2: toggling straps never latch; latch 4 samples into the hold.
    $display("[TB] scenario 2: toggling straps");
    applyStimulus(3'b010, 1'b1);
    tick(2);
    applyStimulus(3'b010, 1'b0);
    for (int p = 0; p < 20; p++) begin
      bus_if.strap_in = (p % 2 == 0) ? 3'b010 : 3'b000;
      tick(2);
    end
    checkOutput("s2 no latch while toggling", 32'(bus_if.id_valid), 32'd0);
    pushExp(16'h7016, 1'b0, "s2");
    bus_if.strap_in = 3'b010;
    tick(5);
    checkOutput("s2 not yet latched", 32'(bus_if.id_valid), 32'd0);
    tick(1);
    checkOutput("s2 latched on 4th sample", 32'(bus_if.id_valid), 32'd1);

    // Scenario 6: power-down during DRVON, backlight must stay off.
    $display("[TB] scenario 6: pd_req in DRVON");
    waitSig("s6 rgb_oe rise", 2, 1'b1, 60, -1, cyc);
    blSeen = 1'b0;
    tick(1);
    pulseReq(1'b1, 1'b0);
    checkOutput("s6 drv_rst low in BLOFF", 32'(bus_if.drv_rst), 32'd0);
    waitSig("s6 drv_rst rise", 3, 1'b1, 40, -1, cyc);
    checkOutput("s6 BLOFF length", 32'(cyc), 32'd5);
    checkOutput("s6 rgb_oe off", 32'(bus_if.rgb_oe), 32'd0);
    tick(10);
    checkOutput("s6 lcd_bl never rose", 32'(blSeen), 32'd0);
    checkOutput("s6 ready low", 32'(bus_if.ready), 32'd0);

    // pu_req and pd_req together in OFF: power-up wins.
    pushExp(16'h7016, 1'b0, "s6 restart");
    pulseReq(1'b1, 1'b1);
    checkOutput("off pu wins id_valid", 32'(bus_if.id_valid), 32'd0);
    waitSig("off restart id_valid", 0, 1'b1, 100, -1, cyc);
    checkOutput("off restart latency", 32'(cyc), 32'd11);
    tick(2);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
